// File: rtl/vga_pkg.sv
// Shared VGA timing constants (640x480@60 defaults) and counter-width helpers.
package vga_pkg;

    localparam int unsigned DEF_PIX_DIV  = 4;
    localparam int unsigned DEF_H_VIS    = 640;
    localparam int unsigned DEF_H_FP     = 16;
    localparam int unsigned DEF_H_SYNC   = 96;
    localparam int unsigned DEF_H_BP     = 48;
    localparam int unsigned DEF_V_VIS    = 480;
    localparam int unsigned DEF_V_FP     = 10;
    localparam int unsigned DEF_V_SYNC   = 2;
    localparam int unsigned DEF_V_BP     = 33;
    localparam bit          DEF_SYNC_POL = 1'b0;

    localparam int unsigned DEF_H_TOTAL = DEF_H_VIS + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int unsigned DEF_V_TOTAL = DEF_V_VIS + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

    // Bits needed to hold 0..value-1.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int i = 0; i < 32; i++) begin
            if (((value - 1) >> i) != 0) begin
                result = unsigned'(i + 1);
            end
        end
        return result;
    endfunction

    // Same as clog2, but never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned value);
        return (clog2(value) < 1) ? 1 : clog2(value);
    endfunction

endpackage

// File: rtl/vga_pix_tick.sv
// Divide-by-PIX_DIV enable generator: one-clk pix_tick per pixel period, no derived clock.
module vga_pix_tick
    import vga_pkg::*;
#(
    parameter int unsigned PIX_DIV = DEF_PIX_DIV
) (
    input  logic clk,
    input  logic rst,
    output logic pix_tick
);

    localparam int unsigned   DW   = cnt_width(PIX_DIV);
    localparam logic [DW-1:0] LAST = DW'(PIX_DIV - 1);

    logic [DW-1:0] div_cnt_q, div_cnt_d;
    logic          pix_tick_q;

    always_comb begin
        div_cnt_d = (div_cnt_q == LAST) ? '0 : div_cnt_q + 1'b1;
    end

    // With PIX_DIV=1 the counter sits at LAST, so the tick stays high after the first edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt_q  <= '0;
            pix_tick_q <= 1'b0;
        end else begin
            div_cnt_q  <= div_cnt_d;
            pix_tick_q <= (div_cnt_q == LAST);
        end
    end

    assign pix_tick = pix_tick_q;

endmodule

// File: rtl/vga_sync_gen.sv
// VGA raster timing: pixel/line counters, sync decode, display enable and line/frame strobes.
module vga_sync_gen
    import vga_pkg::*;
#(
    parameter int unsigned PIX_DIV  = DEF_PIX_DIV,
    parameter int unsigned H_VIS    = DEF_H_VIS,
    parameter int unsigned H_FP     = DEF_H_FP,
    parameter int unsigned H_SYNC   = DEF_H_SYNC,
    parameter int unsigned H_BP     = DEF_H_BP,
    parameter int unsigned V_VIS    = DEF_V_VIS,
    parameter int unsigned V_FP     = DEF_V_FP,
    parameter int unsigned V_SYNC   = DEF_V_SYNC,
    parameter int unsigned V_BP     = DEF_V_BP,
    parameter bit          SYNC_POL = DEF_SYNC_POL,
    localparam int unsigned H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP,
    localparam int unsigned V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP,
    localparam int unsigned HW      = cnt_width(H_TOTAL),
    localparam int unsigned VW      = cnt_width(V_TOTAL)
) (
    input  logic          clk,
    input  logic          rst,
    output logic          pix_tick,
    output logic [HW-1:0] h_count,
    output logic [VW-1:0] v_count,
    output logic          hsync,
    output logic          vsync,
    output logic          video_on,
    output logic          line_start,
    output logic          frame_start
);

    localparam logic [HW-1:0] H_LAST      = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_VIS_END   = HW'(H_VIS);
    localparam logic [HW-1:0] H_SYNC_BEG  = HW'(H_VIS + H_FP);
    localparam logic [HW-1:0] H_SYNC_LAST = HW'(H_VIS + H_FP + H_SYNC - 1);
    localparam logic [VW-1:0] V_LAST      = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_VIS_END   = VW'(V_VIS);
    localparam logic [VW-1:0] V_SYNC_BEG  = VW'(V_VIS + V_FP);
    localparam logic [VW-1:0] V_SYNC_LAST = VW'(V_VIS + V_FP + V_SYNC - 1);

    logic          tick;
    logic [HW-1:0] h_q, h_d;
    logic [VW-1:0] v_q, v_d;
    logic          line_q, line_d;
    logic          frame_q, frame_d;

    vga_pix_tick #(
        .PIX_DIV (PIX_DIV)
    ) u_pix_tick (
        .clk      (clk),
        .rst      (rst),
        .pix_tick (tick)
    );

    // Strobes are computed from the pre-wrap counters so they line up with the first 0 shown.
    always_comb begin
        h_d     = h_q;
        v_d     = v_q;
        line_d  = 1'b0;
        frame_d = 1'b0;
        if (tick) begin
            if (h_q == H_LAST) begin
                h_d    = '0;
                line_d = 1'b1;
                if (v_q == V_LAST) begin
                    v_d     = '0;
                    frame_d = 1'b1;
                end else begin
                    v_d = v_q + 1'b1;
                end
            end else begin
                h_d = h_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_q     <= '0;
            v_q     <= '0;
            line_q  <= 1'b0;
            frame_q <= 1'b0;
        end else begin
            h_q     <= h_d;
            v_q     <= v_d;
            line_q  <= line_d;
            frame_q <= frame_d;
        end
    end

    // Sync and enable are pure decodes of the registered counters, so reset clears them at once.
    always_comb begin
        hsync    = ((h_q >= H_SYNC_BEG) && (h_q <= H_SYNC_LAST)) ? SYNC_POL : ~SYNC_POL;
        vsync    = ((v_q >= V_SYNC_BEG) && (v_q <= V_SYNC_LAST)) ? SYNC_POL : ~SYNC_POL;
        video_on = (h_q < H_VIS_END) && (v_q < V_VIS_END);
    end

    assign pix_tick    = tick;
    assign h_count     = h_q;
    assign v_count     = v_q;
    assign line_start  = line_q;
    assign frame_start = frame_q;

    a_frame_has_line: assert property (@(posedge clk) disable iff (rst) frame_start |-> line_start);
    a_line_at_zero: assert property (@(posedge clk) disable iff (rst) line_start |-> (h_q == '0));
    a_h_in_range: assert property (@(posedge clk) disable iff (rst) h_q <= H_LAST);
    a_v_in_range: assert property (@(posedge clk) disable iff (rst) v_q <= V_LAST);

endmodule

// File: doc/vga_sync_gen.md
Name: vga_sync_gen

Overview:
- Generates VGA raster timing: horizontal and vertical pixel counters, hsync/vsync, display-enable and frame/line strobes.
- Runs entirely in the system clock domain; no derived clock.
- Pixel rate comes from an internal pixel-enable strobe (divide-by-PIX_DIV of clk).
- Sits between the clock/reset infrastructure and the pixel source (framebuffer/pattern logic), which uses x/y/video_on on the same clk.

Parameters:
- PIX_DIV, 4, clk cycles per pixel (>=1); 100 MHz clk gives a 25 MHz pixel rate.
- H_VIS, 640, visible pixels per line.
- H_FP, 16, horizontal front porch, in pixels.
- H_SYNC, 96, hsync width, in pixels.
- H_BP, 48, horizontal back porch, in pixels.
- V_VIS, 480, visible lines.
- V_FP, 10, vertical front porch, in lines.
- V_SYNC, 2, vsync width, in lines.
- V_BP, 33, vertical back porch, in lines.
- SYNC_POL, 0, active level of hsync/vsync (0 = active-low).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- pix_tick  out  1  one-clk pulse each pixel period
- h_count  out  HW  horizontal position 0..H_TOTAL-1; HW = clog2(H_TOTAL)
- v_count  out  VW  vertical position 0..V_TOTAL-1; VW = clog2(V_TOTAL)
- hsync  out  1  horizontal sync, polarity per SYNC_POL
- vsync  out  1  vertical sync, polarity per SYNC_POL
- video_on  out  1  high while h_count<H_VIS and v_count<V_VIS
- line_start  out  1  one-clk pulse when h_count wraps to 0
- frame_start  out  1  one-clk pulse when (h_count,v_count) wraps to (0,0)

Behaviour:
- Interface: one clock, clk. rst is asynchronous and active-high.
- Totals: H_TOTAL = H_VIS+H_FP+H_SYNC+H_BP = 800; V_TOTAL = V_VIS+V_FP+V_SYNC+V_BP = 525.
- Pixel divider:
  - div_cnt counts 0..PIX_DIV-1 on every clk and wraps.
  - pix_tick is registered; it is 1 in the clk cycle after div_cnt==PIX_DIV-1.
  - PIX_DIV=1: pix_tick is constantly 1 after the first clk following reset.
- Counters advance only on a clk edge where pix_tick==1:
  - h_count increments.
  - At H_TOTAL-1, h_count wraps to 0 and v_count increments.
  - At (H_TOTAL-1, V_TOTAL-1), both counters wrap to 0.
  - No other value sequence is legal.
- hsync:
  - Active for h_count in [H_VIS+H_FP, H_VIS+H_FP+H_SYNC-1] = 656..751.
  - Combinational decode of the registered h_count, so it is aligned with h_count.
- vsync: active for v_count in [V_VIS+V_FP, V_VIS+V_FP+V_SYNC-1] = 490..491, for whole lines.
- video_on: combinational decode of the registered counters, aligned with them.
- line_start: registered; high for exactly one clk, the cycle in which h_count first shows 0 after a wrap.
- frame_start: registered; same rule as line_start, for the (0,0) wrap. Whenever frame_start is high, line_start is also high.
- Reset values (while rst high and immediately after release):
  - div_cnt=0, pix_tick=0
  - h_count=0, v_count=0
  - hsync=vsync=~SYNC_POL (inactive)
  - video_on=1 (decode of 0,0)
  - line_start=frame_start=0
- Reset release does not produce a frame_start pulse; the first frame_start comes on the first wrap.
- Reset mid-frame: all state returns to reset values asynchronously. No partial sync pulse persists after rst rises.
- Counter widths: HW and VW are sized from the totals. Comparisons use full-width constants. Counter overflow is unreachable.
- Legal parameters: each porch and sync width >=1, PIX_DIV>=1. No runtime reconfiguration.

Decomposition:
- Shared package vga_pkg holds:
  - the default 640x480@60 timing constants (visible, porch and sync widths, totals);
  - the counter-width helper (clog2).
- Sub-module vga_pix_tick: parameterised PIX_DIV divider producing the single-cycle pix_tick enable. It is reusable by other pixel-domain blocks and replaces derived-clock generation.

Test Plan:
- Reset: hold rst for 5 clks with PIX_DIV=4 -> h_count=0, v_count=0, hsync=vsync=1, video_on=1, line_start=frame_start=0.
- Reset release: -> pix_tick first high on clk 4 after release, then every 4 clks; h_count=1 after the first tick.
- Horizontal line: run one line -> hsync low exactly for h_count 656..751 (96 ticks = 384 clks); video_on low from h_count 640 to 799.
- Line wrap:
  - h_count 799 -> 0, v_count 0 -> 1;
  - line_start high exactly 1 clk;
  - frame_start stays 0.
- Full frame:
  - vsync low only on v_count 490..491;
  - at (799,524) the next tick gives (0,0) with frame_start and line_start both high 1 clk;
  - frame length = 800*525*4 = 1,680,000 clks.
- Variants:
  - PIX_DIV=1: counters advance every clk; frame = 420,000 clks.
  - Mid-line reset: assert rst at h_count=700 (inside hsync) -> hsync inactive and counters 0 within the same cycle, without waiting for a clk edge.
